// File: rtl/cpu_types_pkg.sv
// Shared types for the two-core memory arbiter: RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick: data before instruction, pointer core before the other core.
module mem_arb_select
    import cpu_types_pkg::*;
(
    input  logic [1:0] ireq,
    input  logic [1:0] dreq,
    input  logic       ptr,
    output logic       sel_cpu,
    output logic       sel_data,
    output logic       sel_valid
);

    always_comb begin
        sel_cpu   = 1'b0;
        sel_data  = 1'b0;
        sel_valid = 1'b1;
        if (dreq[ptr]) begin
            sel_cpu  = ptr;
            sel_data = 1'b1;
        end else if (dreq[~ptr]) begin
            sel_cpu  = ~ptr;
            sel_data = 1'b1;
        end else if (ireq[ptr]) begin
            sel_cpu  = ptr;
        end else if (ireq[~ptr]) begin
            sel_cpu  = ~ptr;
        end else begin
            sel_valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core shared-RAM arbiter: one transaction at a time, round-robin between cores,
// data accesses ahead of instruction fetches.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NCPU   = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NCPU-1:0]               iREN,
    input  logic [NCPU-1:0]               dREN,
    input  logic [NCPU-1:0]               dWEN,
    input  logic [NCPU-1:0][ADDR_W-1:0]   iaddr,
    input  logic [NCPU-1:0][ADDR_W-1:0]   daddr,
    input  logic [NCPU-1:0][ADDR_W-1:0]   dstore,
    output logic [NCPU-1:0]               iwait,
    output logic [NCPU-1:0]               dwait,
    output logic [ADDR_W-1:0]             iload,
    output logic [ADDR_W-1:0]             dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [ADDR_W-1:0]             ramstore,
    input  logic [ADDR_W-1:0]             ramload,
    input  logic [1:0]                    ramstate,
    output logic                          gnt_cpu,
    output logic                          gnt_data
);

    // Handshake: a held request is the core's valid; the matching wait going low while
    // the request is high is the single-cycle completion, and the core may then move on.
    arb_state_t      state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            own_cpu_q, own_cpu_d;
    logic            own_data_q, own_data_d;
    logic [NCPU-1:0] dreq;
    logic            own_req;
    logic            done;
    logic            sel_cpu, sel_data, sel_valid;

    assign dreq    = dREN | dWEN;
    assign own_req = own_data_q ? dreq[own_cpu_q] : iREN[own_cpu_q];
    assign iload   = ramload;
    assign dload   = ramload;
    assign gnt_cpu  = own_cpu_q;
    assign gnt_data = own_data_q;

    mem_arb_select u_select (
        .ireq      (iREN[1:0]),
        .dreq      (dreq[1:0]),
        .ptr       (ptr_q),
        .sel_cpu   (sel_cpu),
        .sel_data  (sel_data),
        .sel_valid (sel_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_cpu_d  = own_cpu_q;
        own_data_d = own_data_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d    = SERVE;
                    own_cpu_d  = sel_cpu;
                    own_data_d = sel_data;
                end
            end
            SERVE: begin
                if (!own_req) begin
                    state_d = IDLE;
                end else begin
                    if (own_data_q) begin
                        ramaddr = daddr[own_cpu_q];
                        if (dWEN[own_cpu_q]) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore[own_cpu_q];
                        end else begin
                            ramREN = 1'b1;
                        end
                    end else begin
                        ramaddr = iaddr[own_cpu_q];
                        ramREN  = 1'b1;
                    end
                    // ERROR and BUSY/FREE simply hold: the owner keeps retrying.
                    if (ramstate_t'(ramstate) == ACCESS) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        ptr_d   = ~own_cpu_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (RST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            done     = 1'b0;
        end
    end

    always_comb begin
        for (int c = 0; c < NCPU; c++) begin
            iwait[c] = iREN[c] & ~(done & ~own_data_q & (int'(own_cpu_q) == c));
            dwait[c] = dreq[c] & ~(done &  own_data_q & (int'(own_cpu_q) == c));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            own_cpu_q  <= 1'b0;
            own_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            own_cpu_q  <= own_cpu_d;
            own_data_q <= own_data_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of every address and data port.
REQ-002 Parameter NCPU, default 2, number of cores; only 2 is supported.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 iREN  in  NCPU  per-core instruction read request.
REQ-006 dREN  in  NCPU  per-core data read request.
REQ-007 dWEN  in  NCPU  per-core data write request.
REQ-008 iaddr  in  NCPU x ADDR_W  per-core instruction address.
REQ-009 daddr  in  NCPU x ADDR_W  per-core data address.
REQ-010 dstore  in  NCPU x ADDR_W  per-core write data.
REQ-011 iwait  out  NCPU  per-core instruction stall; 0 means the access completes this cycle.
REQ-012 dwait  out  NCPU  per-core data stall; same meaning as iwait.
REQ-013 iload, dload  out  ADDR_W each  ramload broadcast to all cores.
REQ-014 ramREN, ramWEN  out  1 each  shared RAM strobes.
REQ-015 ramaddr, ramstore  out  ADDR_W each  shared RAM address and write data.
REQ-016 ramload  in  ADDR_W  RAM read data.
REQ-017 ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-018 gnt_cpu  out  1  core currently owning the RAM (debug).
REQ-019 gnt_data  out  1  1 when the owner's access is data, 0 when instruction (debug).

Function
REQ-020 FSM states: IDLE and SERVE.
REQ-021 IDLE with no request: stay in IDLE; ramREN=0, ramWEN=0.
REQ-022 IDLE with any request: register one winner (cpu, type) and go to SERVE next cycle.
REQ-023 Winner priority, where P is the round-robin pointer core: data of P > data of ~P > instruction of P > instruction of ~P.
REQ-024 A data request is any core with dREN|dWEN; when both are high, dWEN wins (write).
REQ-025 SERVE drives RAM combinationally from the owner's live inputs: ramaddr, ramREN/ramWEN by type, ramstore=dstore for writes.
REQ-026 SERVE and ramstate==ACCESS: deassert the owner's matching wait that cycle, go to IDLE next cycle, set P to the other core.
REQ-027 SERVE and ramstate in FREE or BUSY: hold the owner and state.
REQ-028 SERVE and ramstate==ERROR: hold and retry; no completion is signalled.
REQ-029 SERVE with the owner's request dropped: abort to IDLE next cycle, strobes 0, P unchanged.
REQ-030 wait[c] = request[c] AND NOT (completion for c this cycle); wait is 0 whenever no request is present.
REQ-031 Minimum latency: request first seen in IDLE at cycle N completes at cycle N+1 when the RAM returns ACCESS.
REQ-032 One transaction at a time; back-to-back grants are separated by one IDLE cycle.
REQ-033 No starvation: a pending request is served within 4 grants.
REQ-034 Arbiter never drives ramREN and ramWEN high together.

Reset
REQ-035 RST high at a clock edge: state=IDLE, P=core 0, gnt_cpu=0, gnt_data=0.
REQ-036 During RST, ramREN=0 and ramWEN=0; ramaddr and ramstore are 0.
REQ-037 RST mid-SERVE aborts the access with no completion; pending requests re-arbitrate after RST falls.

Structure
REQ-038 ramstate_t and arb_state_t (IDLE, SERVE) live in cpu_types_pkg.
REQ-039 The priority pick (requests + P -> cpu, type, valid) is a combinational sub-module, mem_arb_select.

Verification
REQ-040 Single read: core0 iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x40, iwait[0]=1 for 3 cycles, then 0 with iload=ramload.
REQ-041 Data before instruction: core0 iREN and core1 dREN rise in the same cycle with P=0 -> core1 data served first, then core0 instruction.
REQ-042 Round-robin: both cores hold dREN continuously -> grants alternate 0,1,0,1 and each dwait completes every other transaction.
REQ-043 Write priority: core1 dREN=1 and dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-044 Abort: core0 drops dREN in SERVE -> IDLE next cycle, P stays 0, no dwait completion.
REQ-045 Reset mid-SERVE: RST=1 while ramstate=BUSY -> strobes 0 the next cycle, state IDLE, P=0.
